// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE, ST_CALC, ST_FIXUP, ST_DONE
   } state_e;

   localparam int W_ITER = 32;

   function automatic logic op_is_div(input op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic op_is_rem(input op_e op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   function automatic logic op_signed_a(input op_e op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic op_signed_b(input op_e op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One MSB-first iteration: shift-add for multiply, shift-subtract-restore for divide.
// For divide the accumulator holds {remainder, quotient}.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int N = 64
) (
   input  logic           is_div,
   input  logic [2*N-1:0] acc,
   input  logic [N-1:0]   mcand,
   input  logic [N-1:0]   divisor,
   input  logic           next_bit,
   output logic [2*N-1:0] acc_next
);

   logic [2*N-1:0] add_term;
   logic [N:0]     shifted;
   logic [N:0]     diff;
   logic           fits;

   always_comb begin
      add_term = '0;
      shifted  = {acc[2*N-1:N], next_bit};
      diff     = shifted - {1'b0, divisor};
      fits     = (shifted >= {1'b0, divisor});
      if (next_bit)
         add_term = {{N{1'b0}}, mcand};
      if (is_div)
         acc_next = {(fits ? diff[N-1:0] : shifted[N-1:0]), acc[N-2:0], fits};
      else
         acc_next = {acc[2*N-2:0], 1'b0} + add_term;
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: operands are reduced to magnitudes on issue,
// iterated K times, then sign-corrected in FIXUP before the one-cycle DONE.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic         w_arith,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         flush,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result
);

   localparam int CW = $clog2(N);

   state_e         state, state_next;
   op_e            op_in, op_q;
   logic           w_q, sign_a_q, neg_res_q;
   logic [N-1:0]   abs_a_q, abs_b_q, result_q;
   logic [2*N-1:0] acc_q, acc_next;
   logic [CW-1:0]  cnt_q, cnt_load;

   logic           sign_a, sign_b, div_zero, div_ovf, special, accept;
   logic [N-1:0]   a_k, b_k, abs_a, abs_b, min_k, ones_k, special_raw, special_res;
   logic [2*N-1:0] prod_fix;
   logic [N-1:0]   quo_fix, rem_fix, sel, fix_res;
   logic           next_bit;

   function automatic logic [N-1:0] sext_w(input logic [N-1:0] v);
      logic signed [31:0] lo;
      lo = v[31:0];
      return N'(lo);
   endfunction

   // W operands are the low 32 bits; everything below works on K-bit values.
   always_comb begin
      op_in    = op_e'(op);
      a_k      = w_arith ? N'(a[31:0]) : a;
      b_k      = w_arith ? N'(b[31:0]) : b;
      min_k    = w_arith ? N'(32'h8000_0000) : {1'b1, {(N-1){1'b0}}};
      ones_k   = w_arith ? N'(32'hFFFF_FFFF) : '1;
      sign_a   = op_signed_a(op_in) && (w_arith ? a[31] : a[N-1]);
      sign_b   = op_signed_b(op_in) && (w_arith ? b[31] : b[N-1]);
      abs_a    = sign_a ? ((~a_k + N'(1)) & ones_k) : a_k;
      abs_b    = sign_b ? ((~b_k + N'(1)) & ones_k) : b_k;
      div_zero = op_is_div(op_in) && (b_k == '0);
      div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (a_k == min_k) && (b_k == ones_k);
      special  = div_zero || div_ovf;
      if (div_zero)
         special_raw = op_is_rem(op_in) ? a : '1;
      else
         special_raw = op_is_rem(op_in) ? '0 : a;
      special_res = w_arith ? sext_w(special_raw) : special_raw;
      cnt_load    = w_arith ? CW'(W_ITER - 1) : CW'(N - 1);
      accept      = start && !flush && (state == ST_IDLE || state == ST_DONE);
   end

   assign next_bit = op_is_div(op_q) ? abs_a_q[cnt_q] : abs_b_q[cnt_q];

   muldiv_step #(.N(N)) u_step (
      .is_div   (op_is_div(op_q)),
      .acc      (acc_q),
      .mcand    (abs_a_q),
      .divisor  (abs_b_q),
      .next_bit (next_bit),
      .acc_next (acc_next)
   );

   always_comb begin
      prod_fix = neg_res_q ? -acc_q : acc_q;
      quo_fix  = neg_res_q ? -acc_q[N-1:0] : acc_q[N-1:0];
      rem_fix  = sign_a_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
      case (op_q)
         OP_MUL:                       sel = prod_fix[N-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: sel = w_q ? prod_fix[W_ITER +: N] : prod_fix[N +: N];
         OP_DIV, OP_DIVU:              sel = quo_fix;
         default:                      sel = rem_fix;
      endcase
      fix_res = w_q ? sext_w(sel) : sel;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE:  if (accept) state_next = special ? ST_DONE : ST_CALC;
         ST_CALC:  if (cnt_q == '0) state_next = ST_FIXUP;
         ST_FIXUP: state_next = ST_DONE;
         ST_DONE:  state_next = accept ? (special ? ST_DONE : ST_CALC) : ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
      if (flush)
         state_next = ST_IDLE;
      busy = (state == ST_CALC) || (state == ST_FIXUP);
      done = (state == ST_DONE);
   end

   // Special-case divides write result at issue; normal ops write it leaving FIXUP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q      <= OP_MUL;
         w_q       <= 1'b0;
         sign_a_q  <= 1'b0;
         neg_res_q <= 1'b0;
         abs_a_q   <= '0;
         abs_b_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
      end else if (accept) begin
         op_q      <= op_in;
         w_q       <= w_arith;
         sign_a_q  <= sign_a;
         neg_res_q <= sign_a ^ sign_b;
         abs_a_q   <= abs_a;
         abs_b_q   <= abs_b;
         acc_q     <= '0;
         cnt_q     <= cnt_load;
         if (special)
            result_q <= special_res;
      end else if (state == ST_CALC && !flush) begin
         acc_q <= acc_next;
         cnt_q <= cnt_q - CW'(1);
      end else if (state == ST_FIXUP && !flush) begin
         result_q <= fix_res;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq against a wide-arithmetic reference model.
module tb_muldiv_seq;

   localparam int N = 64;

   logic         clk = 1'b0;
   logic         reset, start, w_arith, flush;
   logic [2:0]   op;
   logic [N-1:0] a, b;
   logic         busy, done;
   logic [N-1:0] result;

   int           checks = 0;
   int           errors = 0;
   logic [63:0]  last_res;

   muldiv_seq #(.N(N)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .w_arith (w_arith),
      .a       (a),
      .b       (b),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // Reference: full-width products and truncating division on 128-bit values.
   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic w,
                                              input logic [63:0] x, input logic [63:0] y);
      int           k;
      logic         sa, sb;
      logic [127:0] ea, eb, p, r;
      k  = w ? 32 : 64;
      sa = o inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
      sb = o inside {3'd0, 3'd1, 3'd4, 3'd6};
      if (w) begin
         ea = sa ? 128'($signed(x[31:0])) : 128'(x[31:0]);
         eb = sb ? 128'($signed(y[31:0])) : 128'(y[31:0]);
      end else begin
         ea = sa ? 128'($signed(x)) : 128'(x);
         eb = sb ? 128'($signed(y)) : 128'(y);
      end
      p = ea * eb;
      case (o)
         3'd0:             r = p;
         3'd1, 3'd2, 3'd3: r = p >> k;
         default: begin
            if (eb == '0)
               r = (o == 3'd4 || o == 3'd5) ? '1 : ea;
            else if (sa)
               r = (o == 3'd4) ? 128'($signed(ea) / $signed(eb)) : 128'($signed(ea) % $signed(eb));
            else
               r = (o == 3'd5) ? ea / eb : ea % eb;
         end
      endcase
      return w ? 64'($signed(r[31:0])) : r[63:0];
   endfunction

   function automatic int ref_latency(input logic [2:0] o, input logic w,
                                      input logic [63:0] x, input logic [63:0] y);
      logic [63:0] xk, yk;
      xk = w ? {32'b0, x[31:0]} : x;
      yk = w ? {32'b0, y[31:0]} : y;
      if (o < 3'd4)
         return w ? 34 : 66;
      if (yk == '0)
         return 1;
      if ((o == 3'd4 || o == 3'd6) && xk == (w ? 64'h8000_0000 : 64'h8000_0000_0000_0000)
          && yk == (w ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF))
         return 1;
      return w ? 34 : 66;
   endfunction

   task automatic apply_stimulus(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
      start   = 1'b1;
      op      = o;
      w_arith = w;
      a       = x;
      b       = y;
   endtask

   task automatic wait_done(input string tag, input int lat, input logic [63:0] want);
      int n;
      n = 1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_output({tag, "_busy1"}, 64'(busy), 64'(lat > 1));
      if (lat > 1)
         check_output({tag, "_hold"}, result, last_res);
      while (!done && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output({tag, "_lat"}, 64'(n), 64'(lat));
      check_output({tag, "_res"}, result, want);
      last_res = want;
   endtask

   task automatic idle_check(input string tag);
      start = 1'b0;
      @(posedge clk);
      #1;
      check_output({tag, "_pulse"}, 64'({busy, done}), 64'(0));
      check_output({tag, "_keep"}, result, last_res);
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                         input logic [63:0] x, input logic [63:0] y, input logic [63:0] want);
      @(negedge clk);
      apply_stimulus(o, w, x, y);
      wait_done(tag, ref_latency(o, w, x, y), want);
      idle_check(tag);
   endtask

   initial begin
      logic [2:0]  o;
      logic        w, chained;
      logic [63:0] x, y;
      int          seen;

      start = 0; op = 0; w_arith = 0; a = 0; b = 0; flush = 0; reset = 0;
      last_res = '0;
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_busy", 64'(busy), 64'(0));
      check_output("rst_done", 64'(done), 64'(0));
      check_output("rst_result", result, 64'(0));
      @(negedge clk);
      reset = 1'b1;

      run_op("mul_7_m3", 3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("div_m20_6", 3'd4, 1'b0, -64'sd20, 64'd6, -64'sd3);
      run_op("rem_m20_6", 3'd6, 1'b0, -64'sd20, 64'd6, -64'sd2);
      run_op("divu_by0", 3'd5, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("remu_by0", 3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234);
      run_op("divw_ovf", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);

      // Flush at cycle 10 of an in-flight MULHU
      @(negedge clk);
      apply_stimulus(3'd3, 1'b0, '1, '1);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 2; n <= 10; n++) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check_output("flush_busy", 64'(busy), 64'(0));
      seen = 0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check_output("flush_no_done", 64'(seen), 64'(0));
      check_output("flush_keep", result, last_res);
      run_op("mulhu_after_flush", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);

      // Flush wins over a simultaneous start
      @(negedge clk);
      apply_stimulus(3'd0, 1'b0, 64'd3, 64'd5);
      flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      check_output("flush_start_busy", 64'(busy), 64'(0));
      seen = 0;
      repeat (70) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check_output("flush_start_no_done", 64'(seen), 64'(0));

      // Back-to-back issue during DONE
      @(negedge clk);
      apply_stimulus(3'd0, 1'b0, 64'd7, -64'sd3);
      wait_done("b2b_first", 66, 64'hFFFF_FFFF_FFFF_FFEB);
      apply_stimulus(3'd4, 1'b0, -64'sd20, 64'd6);
      wait_done("b2b_second", 66, -64'sd3);
      idle_check("b2b_second");

      chained = 1'b0;
      for (int i = 0; i < 30; i++) begin
         o = 3'($urandom_range(0, 7));
         w = 1'($urandom_range(0, 1));
         x = {$urandom, $urandom};
         y = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: y = '0;
            1: begin
               y = '1;
               x = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
            end
            2: y = 64'($urandom_range(1, 15));
            default: ;
         endcase
         if (!chained)
            @(negedge clk);
         apply_stimulus(o, w, x, y);
         wait_done($sformatf("rnd%0d", i), ref_latency(o, w, x, y), ref_result(o, w, x, y));
         chained = 1'($urandom_range(0, 1));
         if (!chained)
            idle_check($sformatf("rnd%0d", i));
      end
      if (chained)
         idle_check("rnd_end");

      // Asynchronous reset in the middle of CALC
      run_op("mul_pre_rst", 3'd0, 1'b0, 64'd3, 64'd4, 64'd12);
      @(negedge clk);
      apply_stimulus(3'd0, 1'b0, 64'd5, 64'd9);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_output("arst_busy", 64'(busy), 64'(0));
      check_output("arst_done", 64'(done), 64'(0));
      check_output("arst_result", result, 64'(0));
      last_res = '0;
      @(negedge clk);
      reset = 1'b1;
      run_op("mul_post_rst", 3'd0, 1'b0, 64'd5, 64'd9, 64'd45);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter N, default 64, datapath width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  issue request from execute stage.
REQ-005 SHALL have port op  input  3  operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-006 SHALL have port w_arith  input  1  32-bit (W) variant; operands use bits [31:0].
REQ-007 SHALL have port a, b  input  N  operand 1 (dividend/multiplicand) and operand 2 (divisor/multiplier).
REQ-008 SHALL have port flush  input  1  abort the operation in flight.
REQ-009 SHALL have port busy  output  1  operation in flight; the pipeline uses it as a stall.
REQ-010 SHALL have port done  output  1  result valid, one-cycle pulse.
REQ-011 SHALL have port result  output  N  operation result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIXUP, DONE.
REQ-013 SHALL accept start in IDLE or DONE: latch op, w_arith, |a|, |b| and result signs; next state CALC.
REQ-014 SHALL ignore start in CALC and FIXUP.
REQ-015 SHALL run K iterations in CALC: K=N normally, K=32 when w_arith.
  - Iteration counter counts K-1 down to 0.
  - Multiply: radix-2 shift-add into a 2N product register.
  - Divide: restoring shift-subtract, producing quotient and remainder.
REQ-016 SHALL leave CALC for FIXUP when the counter reaches 0, and go from FIXUP to DONE unconditionally.
REQ-017 SHALL apply sign correction in FIXUP:
  - Negate product, quotient or remainder per signedness.
  - Remainder takes the dividend's sign.
REQ-018 SHALL select result:
  - MUL: low K bits.
  - MULH*: high K bits.
  - DIV*: quotient.
  - REM*: remainder.
  - When w_arith: sign-extend bit 31 to N.
REQ-019 SHALL assert done and present a stable result only in DONE; DONE lasts exactly one cycle, then IDLE unless start is accepted.
REQ-020 SHALL assert done exactly K+2 cycles after the clock edge that accepted start.
REQ-021 SHALL handle divide by zero without iterating (next state DONE):
  - Quotient is all ones.
  - Remainder is the unmodified dividend.
  - done asserts 1 cycle after acceptance.
REQ-022 SHALL handle signed overflow (most-negative / -1, for K bits) without iterating:
  - Quotient is the dividend.
  - Remainder is 0.
  - done asserts 1 cycle after acceptance.
REQ-023 SHALL drive busy high in CALC and FIXUP, and in the acceptance cycle after start; low in IDLE and DONE.
REQ-024 SHALL, on flush in any state, go to IDLE on the next edge with busy=0 and no done pulse; flush has priority over a simultaneous start.
REQ-025 SHALL hold result at its last value outside DONE.

Reset
REQ-026 SHALL, on reset low, immediately force state=IDLE, busy=0, done=0, result=0, counter=0, independent of clk.
REQ-027 SHALL abandon any operation interrupted by reset; the first accepted start after reset release begins cleanly.

Structure
REQ-028 SHALL take the op enum, FSM state enum and the W-iteration constant 32 from shared package muldiv_pkg.
REQ-029 SHALL place the single-iteration datapath (add-or-pass, subtract-and-restore) in combinational sub-module muldiv_step; the FSM, counter and registers stay in muldiv_seq.

Verification
REQ-030 SHALL cover MUL, a=7, b=-3, w_arith=0 -> done at cycle 66, result=-21 (0xFFFF_FFFF_FFFF_FFEB).
REQ-031 SHALL cover DIV, a=-20, b=6 -> quotient -3; REM same operands -> remainder -2.
REQ-032 SHALL cover DIVU, b=0, a=0x1234 -> done 1 cycle after start, result=all ones; REMU -> result 0x1234.
REQ-033 SHALL cover DIV w_arith=1, a=0x8000_0000, b=-1 -> result 0xFFFF_FFFF_8000_0000, done 1 cycle after start.
REQ-034 SHALL cover MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF with flush at cycle 10 -> busy drops next cycle, no done; a new start then completes normally with result 0xFFFF_FFFF_FFFF_FFFE.
REQ-035 SHALL cover reset asserted low mid-CALC -> busy, done, result all 0 immediately; start during DONE back-to-back -> second done exactly K+2 cycles later.
